mips_ctrl_fsm: RTL and testbench

- Multicycle control unit for the 32-bit MIPS datapath inside top_level.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every mux select and write enable in the datapath, plus the ALU-op class used by the ALU control decoder.
- Input is the 6-bit opcode from the instruction register. All outputs are Moore, decoded from registered state only.

---
 rtl/mips_ctrl_fsm_if.sv | 36 +++
 rtl/mips_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_fsm_if.sv
// Control bundle between the multicycle MIPS control unit and its datapath.
// No handshake: opcode is level-sampled by the FSM, every control line is a per-cycle level.
interface mips_ctrl_fsm_if;
    logic [5:0] opcode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       jump_and_link;
    logic       is_signed;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic [3:0] state_dbg;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, jump_and_link, is_signed,
               alu_src_a, alu_src_b, alu_op, pc_source, halted, state_dbg
    );

    modport slave (
        output opcode,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, jump_and_link, is_signed,
               alu_src_a, alu_src_b, alu_op, pc_source, halted, state_dbg
    );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Controls are registered from the next state, so each cycle's outputs depend only on state.
module mips_ctrl_fsm #(
    parameter int         MEM_RD_LATENCY = 1,
    parameter logic [5:0] HALT_OPCODE    = 6'h3F
) (
    input  logic clk,
    input  logic rst,
    mips_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_MEM_ADDR   = 4'd3,
        S_MEM_RD     = 4'd4,
        S_MEM_WAIT   = 4'd5,
        S_LW_WB      = 4'd6,
        S_SW         = 4'd7,
        S_R_EXEC     = 4'd8,
        S_R_WB       = 4'd9,
        S_I_EXEC     = 4'd10,
        S_I_WB       = 4'd11,
        S_BRANCH     = 4'd12,
        S_JUMP       = 4'd13,
        S_HALT       = 4'd14
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jump_and_link;
        logic       is_signed;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    localparam logic [1:0] LAST = 2'(MEM_RD_LATENCY - 1);

    function automatic ctrl_t ctl_for(state_t s, logic sgn, logic jal, logic last);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_FETCH_WAIT: c.ir_write = last;
            S_DECODE:     c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.is_signed = 1'b1;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_LW_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_SW: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.alu_op    = 2'b10;
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_I_EXEC, S_I_WB: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
                c.is_signed = sgn;
                c.reg_write = (s == S_I_WB);
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write      = 1'b1;
                c.pc_source     = 2'b10;
                c.jump_and_link = jal;
                c.reg_write     = jal;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state, nstate;
    logic [1:0] cnt, ncnt;
    ctrl_t      ctl, nctl;
    logic       imm_signed;
    logic       sgn_next;

    assign imm_signed = bus.opcode inside {6'h09, 6'h10, 6'h0A};

    always_comb begin
        nstate = state;
        ncnt   = '0;
        case (state)
            S_FETCH: nstate = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (cnt == LAST) nstate = S_DECODE;
                else             ncnt   = cnt + 2'd1;
            end
            S_DECODE: begin
                if (bus.opcode == HALT_OPCODE) begin
                    nstate = S_HALT;
                end else begin
                    case (bus.opcode)
                        6'h00:                                     nstate = S_R_EXEC;
                        6'h23, 6'h2B:                              nstate = S_MEM_ADDR;
                        6'h09, 6'h10, 6'h0A, 6'h0B, 6'h0C,
                        6'h0D, 6'h0E:                              nstate = S_I_EXEC;
                        6'h01, 6'h04, 6'h05, 6'h06, 6'h07:         nstate = S_BRANCH;
                        6'h02, 6'h03:                              nstate = S_JUMP;
                        default:                                   nstate = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                if (bus.opcode == 6'h23)      nstate = S_MEM_RD;
                else if (bus.opcode == 6'h2B) nstate = S_SW;
                else                          nstate = S_FETCH;
            end
            S_MEM_RD: nstate = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (cnt == LAST) nstate = S_LW_WB;
                else             ncnt   = cnt + 2'd1;
            end
            S_R_EXEC: nstate = S_R_WB;
            S_I_EXEC: nstate = S_I_WB;
            S_HALT:   nstate = S_HALT;
            default:  nstate = S_FETCH;
        endcase
    end

    // Immediate signedness is latched at DECODE and carried into I_WB from the register.
    assign sgn_next = (state == S_DECODE) ? imm_signed : ctl.is_signed;

    always_comb begin
        nctl = ctl_for(nstate, sgn_next, bus.opcode == 6'h03, ncnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
            cnt   <= '0;
            ctl   <= ctl_for(S_FETCH, 1'b0, 1'b0, 1'b0);
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            ctl   <= nctl;
        end
    end

    // Reset gates every output so nothing toggles while rst is held low.
    assign bus.pc_write      = rst & ctl.pc_write;
    assign bus.pc_write_cond = rst & ctl.pc_write_cond;
    assign bus.i_or_d        = rst & ctl.i_or_d;
    assign bus.mem_read      = rst & ctl.mem_read;
    assign bus.mem_write     = rst & ctl.mem_write;
    assign bus.ir_write      = rst & ctl.ir_write;
    assign bus.mem_to_reg    = rst & ctl.mem_to_reg;
    assign bus.reg_dst       = rst & ctl.reg_dst;
    assign bus.reg_write     = rst & ctl.reg_write;
    assign bus.jump_and_link = rst & ctl.jump_and_link;
    assign bus.is_signed     = rst & ctl.is_signed;
    assign bus.alu_src_a     = rst & ctl.alu_src_a;
    assign bus.alu_src_b     = {2{rst}} & ctl.alu_src_b;
    assign bus.alu_op        = {2{rst}} & ctl.alu_op;
    assign bus.pc_source     = {2{rst}} & ctl.pc_source;
    assign bus.halted        = rst & ctl.halted;
    assign bus.state_dbg     = rst ? state : 4'd0;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Bench for mips_ctrl_fsm: a path-level instruction model feeds an expected queue,
// and a negedge monitor compares every cycle's control vector against it.
module tb_mips_ctrl_fsm;
    localparam int         LAT     = 2;
    localparam int         W       = 23;
    localparam logic [5:0] HALT_OP = 6'h3F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_ctrl_fsm_if bus();

    mips_ctrl_fsm #(.MEM_RD_LATENCY(LAT), .HALT_OPCODE(HALT_OP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           path_q[$];
    int           n_cmp  = 0;
    int           n_bad  = 0;
    int           cyc    = 0;
    bit           mon_en = 1'b0;

    // Expected controls for one cycle, straight from the per-state control table.
    function automatic logic [W-1:0] ref_vec(int st, logic [5:0] op, bit last);
        logic       pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, mtr = 0, rd = 0;
        logic       rw = 0, jl = 0, sg = 0, asa = 0, hl = 0;
        logic [1:0] asb = 0, ao = 0, ps = 0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; pw = 1; end
            1:  irw = last;
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; sg = 1; end
            4:  begin mr = 1; iod = 1; end
            6:  begin rw = 1; mtr = 1; end
            7:  begin mw = 1; iod = 1; end
            8:  begin asa = 1; ao = 2'b10; end
            9:  begin ao = 2'b10; rd = 1; rw = 1; end
            10, 11: begin
                asa = 1; asb = 2'b10; ao = 2'b11;
                sg = (op == 6'h09) || (op == 6'h10) || (op == 6'h0A);
                rw = (st == 11);
            end
            12: begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            13: begin pw = 1; ps = 2'b10; jl = (op == 6'h03); rw = (op == 6'h03); end
            14: hl = 1;
            default: ;
        endcase
        return {4'(st), hl, ps, ao, asb, asa, sg, jl, rw, rd, mtr, irw, mw, mr, iod, pwc, pw};
    endfunction

    // Instruction class: 0 unknown, 1 R, 2 lw, 3 sw, 4 I, 5 branch, 6 jump, 7 halt.
    function automatic int cls(logic [5:0] op);
        if (op == HALT_OP) return 7;
        case (op)
            6'h00: return 1;
            6'h23: return 2;
            6'h2B: return 3;
            6'h09, 6'h10, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: return 4;
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return 5;
            6'h02, 6'h03: return 6;
            default: return 0;
        endcase
    endfunction

    task automatic make_path(input logic [5:0] op);
        path_q.delete();
        path_q.push_back(0);
        for (int i = 0; i < LAT; i++) path_q.push_back(1);
        path_q.push_back(2);
        case (cls(op))
            1: begin path_q.push_back(8); path_q.push_back(9); end
            2: begin
                path_q.push_back(3); path_q.push_back(4);
                for (int i = 0; i < LAT; i++) path_q.push_back(5);
                path_q.push_back(6);
            end
            3: begin path_q.push_back(3); path_q.push_back(7); end
            4: begin path_q.push_back(10); path_q.push_back(11); end
            5: path_q.push_back(12);
            6: path_q.push_back(13);
            7: for (int i = 0; i < 22; i++) path_q.push_back(14);
            default: ;
        endcase
    endtask

    // Opcode is only valid in the cycles where the FSM samples it; junk elsewhere.
    task automatic drive_path(input logic [5:0] op, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            int st;
            bit last;
            st   = path_q[i];
            last = (st == 1) && ((i + 1 >= path_q.size()) || (path_q[i + 1] != 1));
            exp_q.push_back(ref_vec(st, op, last));
            tag_q.push_back($sformatf("op%02h_st%0d", op, st));
            rst        = 1'b1;
            bus.opcode = (st == 2 || st == 3) ? op : 6'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input logic [5:0] op);
        make_path(op);
        drive_path(op, path_q.size());
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('0);
            tag_q.push_back("reset");
            rst        = 1'b0;
            bus.opcode = 6'($urandom);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] got, e;
        string        t;
        if (mon_en) begin
            cyc++;
            got = {bus.state_dbg, bus.halted, bus.pc_source, bus.alu_op, bus.alu_src_b,
                   bus.alu_src_a, bus.is_signed, bus.jump_and_link, bus.reg_write,
                   bus.reg_dst, bus.mem_to_reg, bus.ir_write, bus.mem_write,
                   bus.mem_read, bus.i_or_d, bus.pc_write_cond, bus.pc_write};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL no_expectation cycle %0d: got vec=%h, expected nothing", cyc, got);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                             t, cyc, got[W-1 -: 4], got, e[W-1 -: 4], e);
                end
            end
        end
    end

    logic [5:0] pool [17] = '{6'h00, 6'h23, 6'h2B, 6'h09, 6'h10, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                              6'h0E, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03};
    logic [5:0] directed [8] = '{6'h00, 6'h23, 6'h2B, 6'h0C, 6'h09, 6'h03, 6'h3E, 6'h04};

    initial begin
        logic [5:0] op;
        rst        = 1'b0;
        bus.opcode = 6'h00;
        @(posedge clk); #1;
        mon_en = 1'b1;

        do_reset(3);
        foreach (directed[i]) run_instr(directed[i]);

        // Abort an lw in MEM_ADDR; the next thing seen must be a clean fetch.
        make_path(6'h23);
        drive_path(6'h23, 5);
        do_reset(2);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                op = pool[$urandom_range(0, 16)];
            end else begin
                op = 6'($urandom_range(0, 63));
                if (op == HALT_OP) op = 6'h3E;
            end
            run_instr(op);
        end

        run_instr(HALT_OP);
        do_reset(1);
        run_instr(6'h00);

        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expectations: got %0d unconsumed, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
